div_rem_unit: RTL and testbench
===============================

# div_rem_unit

Multi-cycle RV32M divide/remainder unit sitting beside the execution stage. It accepts DIV/DIVU/REM/REMU requests that the execution stage raises while it holds the instruction stalled. It returns a 32-bit result with a ready strobe, which releases that stall. Normal operands use iterative radix-2 restoring division with a 32-cycle core. Divide-by-zero and signed overflow take a one-cycle fast path.

## Interface
- No parameters; width fixed at 32.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; returns the unit to IDLE.
- acc_in_A  in  32  dividend, already forwarded by the execution stage.
- acc_in_B  in  32  divisor, already forwarded by the execution stage.
- div_rem_order  in  2  operation select = funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- div_rem_order_active  in  1  the instruction in execution is a div/rem.
- hold_in  in  1  pipeline stall from downstream; the execution stage will not capture this cycle.
- flush  in  1  the instruction in execution is squashed.
- div_rem_ready  out  1  result valid this cycle.
- div_rem_result  out  32  quotient or remainder, as selected by div_rem_order.

## Operation
- States:
  - IDLE: no work in progress.
  - BUSY: iterating.
  - DONE: result valid, div_rem_ready=1.
- IDLE → BUSY: div_rem_order_active=1 and flush=0.
  - On this transition, latch the operation, |A|, |B|, and the sign flags.
  - Signed ops (00, 10) take the absolute value of negative operands. Unsigned ops use operands raw.
  - Load the quotient register with |A|, clear the 33-bit partial remainder, and set the iteration counter to 31.
- IDLE → DONE (fast path): taken instead of BUSY when B=0, or when the op is signed with A=0x80000000 and B=0xFFFFFFFF.
- BUSY, each cycle:
  - Shift {rem, quo} left by 1 and compute trial = rem[32:0] − {1'b0,|B|}.
  - If trial is non-negative, rem=trial and the new quo bit is 1; otherwise the bit is 0.
  - When the counter reaches 0, go to DONE and apply sign fixup.
- Sign fixup:
  - The quotient is negated when a signed op has differing operand signs.
  - The remainder is negated when a signed op has a negative dividend.
- Special results:
  - B=0: quotient 0xFFFFFFFF for both DIV and DIVU; remainder = A.
  - Signed overflow: quotient 0x80000000; remainder 0.
- DONE → IDLE: when hold_in=0. While hold_in=1, DONE holds and the result stays stable.
- Flush: in any state, flush=1 sends the unit to IDLE next cycle with ready=0. A request present in the same cycle as flush is ignored.
- The unit never restarts on the cycle after DONE. The request seen in IDLE on that cycle belongs to the next instruction.

## Timing
- Reset values: div_rem_ready=0, div_rem_result=0, state IDLE, all datapath registers 0.
- Let cycle 0 be the first cycle div_rem_order_active is seen in IDLE.
  - Normal path: BUSY occupies cycles 1–32 and ready=1 from cycle 33.
  - Fast path: ready=1 at cycle 1.
- div_rem_ready and div_rem_result are registered. No combinational path runs from the inputs to the outputs.
- Operand changes after cycle 0 are ignored.
- Back-to-back requests: a new request can start in the cycle after DONE exits. The minimum spacing between two normal results is 34 cycles.
- Reset asserted mid-BUSY: outputs return to 0 immediately (asynchronous reset).

## Configuration
- DIV_REM_RESULT_CACHE_EN:
  - Defined:
    - Entry contents: after each completed division the unit keeps A, B, the signedness, the final quotient and the final remainder in a valid-flagged entry.
    - Hit: a new request with matching A, B and signedness goes IDLE → DONE with ready at cycle 1. This covers the DIV-then-REM idiom.
    - Invalidation: flush does not invalidate the entry; reset does.
  - Undefined: every non-special request takes the full 33-cycle path, and no cache storage is synthesised.

## Structure
- Package div_rem_pkg:
  - Op encodings: DR_DIV=2'b00, DR_DIVU=2'b01, DR_REM=2'b10, DR_REMU=2'b11.
  - State typedef {IDLE, BUSY, DONE}.
  - Constants INT_MIN=32'h80000000 and ITER_LAST=5'd31.
- Sub-module div_rem_iter: a combinational single restoring step. It takes {rem, quo, divisor} and returns the next {rem, quo}. The parent holds the FSM, counter, sign fixup and cache.

## Test plan
- DIV 100 / −7 (0xFFFFFFF9) → ready at cycle 33, result 0xFFFFFFF2. REM with the same operands → 0x00000002.
- DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF. REMU with the same operands → 0x00000001. Both at cycle 33.
- Divide by zero:
  - DIV 5 / 0 → 0xFFFFFFFF at cycle 1.
  - REMU 5 / 0 → 0x00000005 at cycle 1.
- Signed overflow:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at cycle 1.
  - REM with the same operands → 0.
- Hold and flush:
  - hold_in=1 for 3 cycles in DONE → ready and result stable for 4 cycles, then IDLE.
  - flush at BUSY cycle 10 → ready never asserts. A following DIV 7/2 returns 3 at cycle 33.
- DIV then REM on 1000 / 33:
  - With DIV_REM_RESULT_CACHE_EN: REM ready at cycle 1 with value 10.
  - Without it: REM ready at cycle 33 with value 10.

Source files
------------

// File: rtl/div_rem_pkg.sv
// Shared encodings, FSM states and constants for the RV32M divide/remainder unit.
package div_rem_pkg;

  localparam logic [1:0] DR_DIV  = 2'b00;
  localparam logic [1:0] DR_DIVU = 2'b01;
  localparam logic [1:0] DR_REM  = 2'b10;
  localparam logic [1:0] DR_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
  localparam logic [4:0]  ITER_LAST = 5'd31;

endpackage

// File: rtl/div_rem_iter.sv
// One combinational radix-2 restoring step: shift {rem, quo} left, try subtracting the divisor.
module div_rem_iter (
  input  logic [32:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [32:0] rem_next,
  output logic [31:0] quo_next
);

  logic [32:0] shifted;
  logic [33:0] trial;
  logic        unused_rem_msb;

  // The partial remainder never exceeds the divisor, so its top bit is always zero.
  assign unused_rem_msb = rem[32];
  assign shifted  = {rem[31:0], quo[31]};
  assign trial    = {1'b0, shifted} - {2'b00, divisor};
  assign rem_next = trial[33] ? shifted : trial[32:0];
  assign quo_next = {quo[30:0], ~trial[33]};

endmodule

// File: rtl/div_rem_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: 32-cycle restoring core plus a one-cycle special-case path.
// Optional result cache enabled by defining DIV_REM_RESULT_CACHE_EN.
module div_rem_unit
  import div_rem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] acc_in_A,
  input  logic [31:0] acc_in_B,
  input  logic [1:0]  div_rem_order,
  input  logic        div_rem_order_active,
  input  logic        hold_in,
  input  logic        flush,
  output logic        div_rem_ready,
  output logic [31:0] div_rem_result,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is taken when div_rem_order_active=1 and flush=0 in IDLE; the
  // result is valid while div_rem_ready=1 and is consumed on the first such cycle with hold_in=0.
  state_t      state;
  logic [1:0]  op;
  logic [31:0] quo, divisor;
  logic [32:0] rem;
  logic [4:0]  cnt;
  logic        neg_q, neg_r;

  logic        in_signed, in_rem, a_neg, b_neg, div_zero, ovf;
  logic [31:0] a_abs, b_abs, fast_result, q_fix, r_fix;
  logic [32:0] rem_nx;
  logic [31:0] quo_nx;
  logic        unused_rem_nx_msb;

  assign in_signed   = (div_rem_order == DR_DIV) || (div_rem_order == DR_REM);
  assign in_rem      = (div_rem_order == DR_REM) || (div_rem_order == DR_REMU);
  assign a_neg       = in_signed & acc_in_A[31];
  assign b_neg       = in_signed & acc_in_B[31];
  assign a_abs       = a_neg ? -acc_in_A : acc_in_A;
  assign b_abs       = b_neg ? -acc_in_B : acc_in_B;
  assign div_zero    = (acc_in_B == 32'd0);
  assign ovf         = in_signed && (acc_in_A == INT_MIN) && (acc_in_B == 32'hFFFF_FFFF);
  assign fast_result = div_zero ? (in_rem ? acc_in_A : 32'hFFFF_FFFF)
                                : (in_rem ? 32'd0 : INT_MIN);

  div_rem_iter u_iter (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  assign unused_rem_nx_msb = rem_nx[32];
  assign q_fix     = neg_q ? -quo_nx : quo_nx;
  assign r_fix     = neg_r ? -rem_nx[31:0] : rem_nx[31:0];
  assign dbg_state = state;

`ifdef DIV_REM_RESULT_CACHE_EN
  logic        c_valid, c_signed, req_signed;
  logic [31:0] c_a, c_b, c_quo, c_rem, req_a, req_b;
  logic        hit;
  assign hit = c_valid && (c_a == acc_in_A) && (c_b == acc_in_B) && (c_signed == in_signed);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      op             <= 2'b00;
      quo            <= 32'd0;
      rem            <= 33'd0;
      divisor        <= 32'd0;
      cnt            <= 5'd0;
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      div_rem_ready  <= 1'b0;
      div_rem_result <= 32'd0;
`ifdef DIV_REM_RESULT_CACHE_EN
      c_valid    <= 1'b0;
      c_signed   <= 1'b0;
      c_a        <= 32'd0;
      c_b        <= 32'd0;
      c_quo      <= 32'd0;
      c_rem      <= 32'd0;
      req_signed <= 1'b0;
      req_a      <= 32'd0;
      req_b      <= 32'd0;
`endif
    end else if (flush) begin
      state         <= IDLE;
      div_rem_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (div_rem_order_active) begin
            if (div_zero || ovf) begin
              state          <= DONE;
              div_rem_ready  <= 1'b1;
              div_rem_result <= fast_result;
`ifdef DIV_REM_RESULT_CACHE_EN
            end else if (hit) begin
              state          <= DONE;
              div_rem_ready  <= 1'b1;
              div_rem_result <= in_rem ? c_rem : c_quo;
`endif
            end else begin
              state   <= BUSY;
              op      <= div_rem_order;
              quo     <= a_abs;
              rem     <= 33'd0;
              divisor <= b_abs;
              neg_q   <= a_neg ^ b_neg;
              neg_r   <= a_neg;
              cnt     <= ITER_LAST;
`ifdef DIV_REM_RESULT_CACHE_EN
              req_a      <= acc_in_A;
              req_b      <= acc_in_B;
              req_signed <= in_signed;
`endif
            end
          end
        end
        BUSY: begin
          quo <= quo_nx;
          rem <= rem_nx;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            state          <= DONE;
            div_rem_ready  <= 1'b1;
            div_rem_result <= op[1] ? r_fix : q_fix;
`ifdef DIV_REM_RESULT_CACHE_EN
            c_valid  <= 1'b1;
            c_a      <= req_a;
            c_b      <= req_b;
            c_signed <= req_signed;
            c_quo    <= q_fix;
            c_rem    <= r_fix;
`endif
          end
        end
        DONE: begin
          if (!hold_in) begin
            state         <= IDLE;
            div_rem_ready <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          div_rem_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_rem_unit.sv
// Bench for div_rem_unit: directed RV32M cases, hold/flush/reset scenarios and random ops
// checked against a plain-arithmetic reference model.
module tb_div_rem_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] acc_in_A = '0;
  logic [31:0] acc_in_B = '0;
  logic [1:0]  div_rem_order = '0;
  logic        div_rem_order_active = 1'b0;
  logic        hold_in = 1'b0;
  logic        flush = 1'b0;
  logic        div_rem_ready;
  logic [31:0] div_rem_result;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  div_rem_unit dut (
    .clk                  (clk),
    .reset                (reset),
    .acc_in_A             (acc_in_A),
    .acc_in_B             (acc_in_B),
    .div_rem_order        (div_rem_order),
    .div_rem_order_active (div_rem_order_active),
    .hold_in              (hold_in),
    .flush                (flush),
    .div_rem_ready        (div_rem_ready),
    .div_rem_result       (div_rem_result),
    .dbg_state            (dbg_state)
  );

  always #5 clk = ~clk;

`ifdef DIV_REM_RESULT_CACHE_EN
  logic        mc_valid = 1'b0;
  logic        mc_signed = 1'b0;
  logic [31:0] mc_a = '0;
  logic [31:0] mc_b = '0;
`endif

  function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (is_special(op, a, b)) return 1;
`ifdef DIV_REM_RESULT_CACHE_EN
    if (mc_valid && mc_a == a && mc_b == b && mc_signed == !op[0]) return 1;
`endif
    return 33;
  endfunction

  task automatic model_complete(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_REM_RESULT_CACHE_EN
    if (!is_special(op, a, b)) begin
      mc_valid = 1'b1; mc_a = a; mc_b = b; mc_signed = !op[0];
    end
`else
    if (is_special(op, a, b) && op === 2'bxx) $display("unreachable");
`endif
  endtask

  // Drives one request, returns cycles from request to ready and the result, then lets DONE exit.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res);
    @(negedge clk);
    div_rem_order = op; acc_in_A = a; acc_in_B = b; div_rem_order_active = 1'b1;
    @(posedge clk); #1;
    div_rem_order_active = 1'b0;
    acc_in_A = $urandom; acc_in_B = $urandom; div_rem_order = 2'($urandom_range(0, 3));
    lat = 1;
    while (!div_rem_ready && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    res = div_rem_result;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++;
    if (div_rem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", div_rem_ready); end
    checks++;
    if (div_rem_result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", div_rem_result); end
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [10] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b11, 2'b00, 2'b10, 2'b01, 2'b10};
    logic [31:0] t_a  [10] = '{32'd100, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5,
                               32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5};
    logic [31:0] t_b  [10] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd2, 32'd2, 32'd0, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] t_exp[10] = '{32'hFFFF_FFF2, 32'd2, 32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd5,
                               32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd5};
    int lat, exp_lat;
    logic [31:0] res;
    for (int i = 0; i < 10; i++) begin
      exp_lat = ref_latency(t_op[i], t_a[i], t_b[i]);
      issue(t_op[i], t_a[i], t_b[i], lat, res);
      model_complete(t_op[i], t_a[i], t_b[i]);
      checks++;
      if (res !== t_exp[i]) begin errors++; $display("FAIL directed_%0d_result got %h want %h", i, res, t_exp[i]); end
      checks++;
      if (lat !== exp_lat) begin errors++; $display("FAIL directed_%0d_latency got %0d want %0d", i, lat, exp_lat); end
    end
  endtask

  task automatic test_div_then_rem();
    int lat;
    logic [31:0] res;
    issue(2'b00, 32'd1000, 32'd33, lat, res);
    model_complete(2'b00, 32'd1000, 32'd33);
    checks++;
    if (res !== 32'd30 || lat !== 33) begin errors++; $display("FAIL div_1000_33 got %0d@%0d want 30@33", res, lat); end
    issue(2'b10, 32'd1000, 32'd33, lat, res);
`ifdef DIV_REM_RESULT_CACHE_EN
    checks++;
    if (res !== 32'd10 || lat !== 1) begin errors++; $display("FAIL rem_1000_33 got %0d@%0d want 10@1", res, lat); end
`else
    checks++;
    if (res !== 32'd10 || lat !== 33) begin errors++; $display("FAIL rem_1000_33 got %0d@%0d want 10@33", res, lat); end
`endif
  endtask

  task automatic test_hold();
    @(negedge clk);
    hold_in = 1'b1; div_rem_order = 2'b00; acc_in_A = 32'd5; acc_in_B = 32'd0; div_rem_order_active = 1'b1;
    @(posedge clk); #1;
    div_rem_order_active = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == 4) hold_in = 1'b0;
      checks++;
      if (div_rem_ready !== 1'b1 || div_rem_result !== 32'hFFFF_FFFF) begin
        errors++; $display("FAIL hold_cycle_%0d got ready=%0b res=%h want 1 ffffffff", k, div_rem_ready, div_rem_result);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (div_rem_ready !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL hold_exit got ready=%0b state=%0d want 0 0", div_rem_ready, dbg_state);
    end
  endtask

  task automatic test_flush();
    int seen, lat;
    logic [31:0] res;
    @(negedge clk);
    div_rem_order = 2'b00; acc_in_A = 32'd9; acc_in_B = 32'd3; div_rem_order_active = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    div_rem_order_active = 1'b0; flush = 1'b0;
    seen = 0;
    for (int k = 0; k < 36; k++) begin @(posedge clk); #1; if (div_rem_ready) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL flush_idle_request got %0d ready cycles want 0", seen); end
    @(negedge clk);
    div_rem_order = 2'b00; acc_in_A = 32'd1000; acc_in_B = 32'd7; div_rem_order_active = 1'b1;
    @(posedge clk); #1;
    div_rem_order_active = 1'b0;
    for (int k = 2; k <= 10; k++) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (div_rem_ready) seen++; end
    checks++;
    if (seen !== 0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL flush_busy got %0d ready cycles state=%0d want 0 0", seen, dbg_state);
    end
    issue(2'b00, 32'd7, 32'd2, lat, res);
    model_complete(2'b00, 32'd7, 32'd2);
    checks++;
    if (res !== 32'd3 || lat !== 33) begin errors++; $display("FAIL after_flush got %0d@%0d want 3@33", res, lat); end
  endtask

  task automatic test_back_to_back();
    int first, second, exp_second;
    logic [31:0] r1, r2;
    logic prev;
    first = 0; second = 0; prev = 1'b0; r1 = '0; r2 = '0;
    @(negedge clk);
    div_rem_order = 2'b01; acc_in_A = 32'd12345; acc_in_B = 32'd67; div_rem_order_active = 1'b1;
    for (int cyc = 1; cyc <= 72; cyc++) begin
      @(posedge clk); #1;
      if (div_rem_ready && !prev) begin
        if (first == 0) begin first = cyc; r1 = div_rem_result; end
        else if (second == 0) begin second = cyc; r2 = div_rem_result; div_rem_order_active = 1'b0; end
      end
      prev = div_rem_ready;
    end
    div_rem_order_active = 1'b0;
    model_complete(2'b01, 32'd12345, 32'd67);
    exp_second = 34 + ref_latency(2'b01, 32'd12345, 32'd67);
    checks++;
    if (first !== 33 || r1 !== 32'd184) begin errors++; $display("FAIL b2b_first got %0d@%0d want 184@33", r1, first); end
    checks++;
    if (second !== exp_second || r2 !== 32'd184) begin
      errors++; $display("FAIL b2b_second got %0d@%0d want 184@%0d", r2, second, exp_second);
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, exp;
    int lat, exp_lat;
    logic [31:0] res;
    a = 32'd1; b = 32'd1;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 || i == 0) begin
        case ($urandom_range(0, 3))
          0: a = 32'h8000_0000;
          1: a = $urandom_range(0, 255);
          default: a = $urandom;
        endcase
        case ($urandom_range(0, 7))
          0: b = 32'd0;
          1: b = 32'hFFFF_FFFF;
          2, 3: b = $urandom_range(1, 100);
          default: b = $urandom;
        endcase
      end
      exp = ref_result(op, a, b);
      exp_lat = ref_latency(op, a, b);
      issue(op, a, b, lat, res);
      model_complete(op, a, b);
      checks++;
      if (res !== exp || lat !== exp_lat) begin
        errors++; $display("FAIL random_%0d op=%0d a=%h b=%h got %h@%0d want %h@%0d", i, op, a, b, res, lat, exp, exp_lat);
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    logic [31:0] res;
    @(negedge clk);
    div_rem_order = 2'b00; acc_in_A = 32'd1000; acc_in_B = 32'd33; div_rem_order_active = 1'b1;
    @(posedge clk); #1;
    div_rem_order_active = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (div_rem_ready !== 1'b0 || div_rem_result !== 32'd0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_mid_busy got ready=%0b res=%h state=%0d want 0 0 0", div_rem_ready, div_rem_result, dbg_state);
    end
    @(negedge clk);
    reset = 1'b1;
`ifdef DIV_REM_RESULT_CACHE_EN
    mc_valid = 1'b0;
`endif
    issue(2'b10, 32'd1000, 32'd33, lat, res);
    checks++;
    if (res !== 32'd10 || lat !== 33) begin errors++; $display("FAIL after_reset_rem got %0d@%0d want 10@33", res, lat); end
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    test_directed();
    test_div_then_rem();
    test_hold();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
